// File: rtl/port_arbiter.sv
//==============================================================================
// Module      : port_arbiter
// Description : Round-robin arbiter + 4-beat byte serializer for one outbound
//               router link. Define PORT_ARB_FIXED_PRI_EN for fixed priority.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module port_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [32*NUM_REQ-1:0]  pkt_in,
   output logic [NUM_REQ-1:0]     grant,
   input  logic                   free_outbound,
   output logic                   put_outbound,
   output logic [7:0]             payload_outbound,
   output logic                   busy
);

   localparam int c_PTR_W = $clog2(NUM_REQ);

   localparam logic [0:0] c_ST_IDLE = 1'b0;
   localparam logic [0:0] c_ST_SEND = 1'b1;

   logic [0:0]          r_state;
   logic [1:0]          r_beat;
   logic [31:0]         r_hold;
   logic [NUM_REQ-1:0]  r_grant;

   logic                w_found;
   logic [c_PTR_W-1:0]  w_win;
   logic [31:0]         w_pkt;
   logic [NUM_REQ-1:0]  w_grant;
   logic                w_start;

`ifdef PORT_ARB_FIXED_PRI_EN
   // Lowest-index requester always wins; no rotation state is kept.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            w_found = 1'b1;
            w_win   = c_PTR_W'(k);
         end
      end
   end
`else
   localparam logic [c_PTR_W:0]   c_NUM  = (c_PTR_W + 1)'(NUM_REQ);
   localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);

   logic [c_PTR_W-1:0]    r_ptr;
   logic [2*NUM_REQ-1:0]  w_dbl;
   logic [NUM_REQ-1:0]    w_rot;
   logic [c_PTR_W-1:0]    w_off;
   logic [c_PTR_W:0]      w_sum;
   logic [c_PTR_W:0]      w_wrap;
   logic [c_PTR_W-1:0]    w_ptr_nxt;

   // Rotate req so that bit 0 is the requester at ptr, then find the first set bit.
   always_comb begin
      w_dbl   = {req, req} >> r_ptr;
      w_rot   = w_dbl[NUM_REQ-1:0];
      w_found = 1'b0;
      w_off   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_found = 1'b1;
            w_off   = c_PTR_W'(k);
         end
      end
      w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
      w_wrap    = (w_sum >= c_NUM) ? (w_sum - c_NUM) : w_sum;
      w_win     = w_wrap[c_PTR_W-1:0];
      w_ptr_nxt = (w_win == c_LAST) ? '0 : (w_win + 1'b1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (w_start) begin
         r_ptr <= w_ptr_nxt;
      end
   end
`endif

   // Winner packet and one-hot grant from the selected index.
   always_comb begin
      w_pkt   = '0;
      w_grant = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (w_win == c_PTR_W'(k)) begin
            w_pkt      = pkt_in[32*k +: 32];
            w_grant[k] = 1'b1;
         end
      end
   end

   assign w_start = (r_state == c_ST_IDLE) && free_outbound && w_found;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_ST_IDLE;
         r_beat  <= 2'd0;
         r_hold  <= '0;
         r_grant <= '0;
      end else begin
         r_grant <= '0;
         case (r_state)
            c_ST_IDLE: begin
               if (w_start) begin
                  r_state <= c_ST_SEND;
                  r_beat  <= 2'd0;
                  r_hold  <= w_pkt;
                  r_grant <= w_grant;
               end
            end
            c_ST_SEND: begin
               r_beat <= r_beat + 2'd1;
               if (r_beat == 2'd3) begin
                  r_state <= c_ST_IDLE;
               end
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      payload_outbound = 8'h00;
      if (r_state == c_ST_SEND) begin
         case (r_beat)
            2'd0:    payload_outbound = r_hold[31:24];
            2'd1:    payload_outbound = r_hold[23:16];
            2'd2:    payload_outbound = r_hold[15:8];
            default: payload_outbound = r_hold[7:0];
         endcase
      end
   end

   assign put_outbound = (r_state == c_ST_SEND);
   assign busy         = (r_state == c_ST_SEND);
   assign grant        = r_grant;

endmodule

`default_nettype wire
